// File: rtl/miim_master.sv
// Clause-22 MDIO management master: serialises one read or write request at a
// time into a preamble + ST/OP/PHYAD/REGAD/TA/DATA frame on MDC/MDIO.
module miim_master #(
  parameter int CLK_DIV = 20,
  parameter int PRE_LEN = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  miim_phyad,
  input  logic [4:0]  miim_regad,
  input  logic [15:0] miim_wrdata,
  input  logic        miim_wren,
  input  logic        miim_rden,
  output logic        busy,
  output logic [15:0] miim_rddata,
  output logic        miim_rddata_valid,
  output logic        miim_rderr,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);

  localparam int NBITS = PRE_LEN + 32;
  localparam int BW    = $clog2(NBITS);
  localparam int DW    = $clog2(CLK_DIV);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] B_ST     = BW'(PRE_LEN);
  localparam logic [BW-1:0] B_ADDR   = BW'(PRE_LEN + 4);
  localparam logic [BW-1:0] B_TA     = BW'(PRE_LEN + 14);
  localparam logic [BW-1:0] B_TA2    = BW'(PRE_LEN + 15);
  localparam logic [BW-1:0] B_DATA   = BW'(PRE_LEN + 16);
  localparam logic [BW-1:0] B_LAST   = BW'(NBITS - 1);

  typedef enum logic [2:0] {IDLE, PRE, STOP, ADDR, TA, DATA} state_t;

  state_t        state_q, state_d;
  logic          busy_q;
  logic          mdc_q;
  logic          mdo_q;
  logic          oe_q;
  logic [DW-1:0] div_q;
  logic [BW-1:0] bit_q, bit_d;
  logic          is_rd_q;
  logic          ack_q;
  logic [15:0]   rddata_q;
  logic          rdvalid_q;
  logic          rderr_q;
  logic [31:0]   frame_q, frame_d;
  logic [15:0]   rd_sr_q;

  logic          accept;
  logic          rd_new;
  logic          tick;
  logic          rise;
  logic          fall;
  logic          last;
  logic          start_slot;
  logic          done;
  logic          released;
  logic          slot_o;
  logic          slot_oe;
  logic [31:0]   frame_src;

  function automatic state_t state_of(input logic [BW-1:0] b);
    if (b < B_ST)   return PRE;
    if (b < B_ADDR) return STOP;
    if (b < B_TA)   return ADDR;
    if (b < B_DATA) return TA;
    return DATA;
  endfunction

  // The 32 post-preamble bits; read frames carry ones where the PHY owns the line
  function automatic logic [31:0] build_frame(input logic rd, input logic [4:0] pa,
                                              input logic [4:0] ra, input logic [15:0] wd);
    if (rd) return {2'b01, 2'b10, pa, ra, 18'h3FFFF};
    return {2'b01, 2'b01, pa, ra, 2'b10, wd};
  endfunction

  assign tick       = (div_q == DIV_LAST);
  assign rise       = busy_q && !mdc_q && tick;
  assign fall       = busy_q && mdc_q && tick;
  assign last       = (bit_q == B_LAST);
  assign accept     = (state_q == IDLE) && !busy_q && (miim_wren || miim_rden);
  assign start_slot = accept || (fall && !last);
  assign done       = fall && last;

  // Values for the slot about to start, either the first slot or the next one
  always_comb begin
    rd_new    = accept ? (miim_rden && !miim_wren) : is_rd_q;
    bit_d     = accept ? '0 : bit_q + BW'(1);
    frame_src = accept ? build_frame(rd_new, miim_phyad, miim_regad, miim_wrdata) : frame_q;
    state_d   = state_of(bit_d);
    released  = rd_new && (state_d == TA || state_d == DATA);
    slot_oe   = !released;
    slot_o    = (state_d == PRE || released) ? 1'b1 : frame_src[31];
    frame_d   = (state_d == PRE) ? frame_src : {frame_src[30:0], 1'b1};
  end

  always_ff @(posedge clk) begin
    if (start_slot) frame_q <= frame_d;
    if (rise && is_rd_q && state_q == DATA) rd_sr_q <= {rd_sr_q[14:0], mdio_i};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      mdc_q     <= 1'b0;
      mdo_q     <= 1'b1;
      oe_q      <= 1'b0;
      div_q     <= '0;
      bit_q     <= '0;
      is_rd_q   <= 1'b0;
      ack_q     <= 1'b0;
      rddata_q  <= '0;
      rdvalid_q <= 1'b0;
      rderr_q   <= 1'b0;
    end else begin
      rdvalid_q <= 1'b0;
      if (start_slot) begin
        state_q <= state_d;
        bit_q   <= bit_d;
        div_q   <= '0;
        mdc_q   <= 1'b0;
        mdo_q   <= slot_o;
        oe_q    <= slot_oe;
        busy_q  <= 1'b1;
        is_rd_q <= rd_new;
        if (accept) ack_q <= 1'b0;
      end else if (done) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
        div_q   <= '0;
        mdc_q   <= 1'b0;
        mdo_q   <= 1'b1;
        oe_q    <= 1'b0;
        if (is_rd_q) begin
          rddata_q  <= rd_sr_q;
          rderr_q   <= ~ack_q;
          rdvalid_q <= 1'b1;
        end
      end else if (busy_q) begin
        if (tick) begin
          // Mid-slot: MDC rises and the PHY's turnaround ack is sampled
          div_q <= '0;
          mdc_q <= 1'b1;
          if (state_q == TA && bit_q == B_TA2) ack_q <= ~mdio_i;
        end else begin
          div_q <= div_q + DW'(1);
        end
      end
    end
  end

  assign busy              = busy_q;
  assign miim_rddata       = rddata_q;
  assign miim_rddata_valid = rdvalid_q;
  assign miim_rderr        = rderr_q;
  assign mdc               = mdc_q;
  assign mdio_o            = mdo_q;
  assign mdio_oe           = oe_q;

endmodule

// File: tb/tb_miim_master.sv
// Directed bench for miim_master with a bit-slot PHY model and a queue of
// expected frame outcomes checked at each busy fall.
module tb_miim_master;

  localparam int CLK_DIV    = 4;
  localparam int PRE_LEN    = 32;
  localparam int FRAME_CLKS = (PRE_LEN + 32) * 2 * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  miim_phyad = '0;
  logic [4:0]  miim_regad = '0;
  logic [15:0] miim_wrdata = '0;
  logic        miim_wren = 1'b0;
  logic        miim_rden = 1'b0;
  logic        busy;
  logic [15:0] miim_rddata;
  logic        miim_rddata_valid;
  logic        miim_rderr;
  logic        mdc;
  logic        mdio_o;
  logic        mdio_oe;
  logic        mdio_line;
  logic        phy_val;

  miim_master #(.CLK_DIV(CLK_DIV), .PRE_LEN(PRE_LEN)) dut (
    .clk               (clk),
    .rst               (rst),
    .miim_phyad        (miim_phyad),
    .miim_regad        (miim_regad),
    .miim_wrdata       (miim_wrdata),
    .miim_wren         (miim_wren),
    .miim_rden         (miim_rden),
    .busy              (busy),
    .miim_rddata       (miim_rddata),
    .miim_rddata_valid (miim_rddata_valid),
    .miim_rderr        (miim_rderr),
    .mdc               (mdc),
    .mdio_o            (mdio_o),
    .mdio_oe           (mdio_oe),
    .mdio_i            (mdio_line)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // PHY model: acks TA with 0 and drives phy_data during the data bits
  logic        phy_on = 1'b0;
  logic [15:0] phy_data = '0;
  int          bit_idx = 64;

  always_comb begin
    phy_val = 1'b1;
    if (phy_on) begin
      if (bit_idx == PRE_LEN + 15) phy_val = 1'b0;
      else if (bit_idx >= PRE_LEN + 16 && bit_idx < PRE_LEN + 32)
        phy_val = phy_data[PRE_LEN + 31 - bit_idx];
    end
  end

  assign mdio_line = mdio_oe ? mdio_o : phy_val;

  logic [63:0] cap = '0;
  logic [63:0] cap_oe = '0;
  int          busy_len = 0;
  int          vld_cnt = 0;
  int          frame_cnt = 0;
  logic        mdc_prev = 1'b0;
  logic        busy_prev = 1'b0;

  always @(negedge clk) begin
    if (busy && !busy_prev) begin
      bit_idx   <= 0;
      busy_len  <= 1;
      vld_cnt   <= 0;
      frame_cnt <= frame_cnt + 1;
      cap       <= '0;
      cap_oe    <= '0;
    end else begin
      if (busy) busy_len <= busy_len + 1;
      if (miim_rddata_valid) vld_cnt <= vld_cnt + 1;
      if (mdc && !mdc_prev) begin
        cap     <= {cap[62:0], mdio_line};
        cap_oe  <= {cap_oe[62:0], mdio_oe};
        bit_idx <= bit_idx + 1;
      end
    end
    mdc_prev  <= mdc;
    busy_prev <= busy;
  end

  typedef struct {
    logic        rd;
    logic [63:0] frame;
    logic [63:0] oe;
    logic [15:0] data;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] exp_rddata = '0;
  logic        exp_rderr = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic request(input logic wr, input logic rd, input logic [4:0] pa,
                         input logic [4:0] ra, input logic [15:0] wd);
    exp_t e;
    @(posedge clk); #1;
    miim_phyad  = pa;
    miim_regad  = ra;
    miim_wrdata = wd;
    miim_wren   = wr;
    miim_rden   = rd;
    e.rd = rd && !wr;
    if (!e.rd) begin
      e.frame = {32'hFFFF_FFFF, 2'b01, 2'b01, pa, ra, 2'b10, wd};
      e.oe    = '1;
    end else if (phy_on) begin
      e.frame    = {32'hFFFF_FFFF, 2'b01, 2'b10, pa, ra, 2'b10, phy_data};
      e.oe       = ~64'h3FFFF;
      exp_rddata = phy_data;
      exp_rderr  = 1'b0;
    end else begin
      e.frame    = {32'hFFFF_FFFF, 2'b01, 2'b10, pa, ra, 2'b11, 16'hFFFF};
      e.oe       = ~64'h3FFFF;
      exp_rddata = 16'hFFFF;
      exp_rderr  = 1'b1;
    end
    e.data = exp_rddata;
    e.err  = exp_rderr;
    sb.push_back(e);
    @(posedge clk); #1;
    miim_wren = 1'b0;
    miim_rden = 1'b0;
    chk("busy_rise", 64'(busy), 64'd1);
  endtask

  task automatic finish_frame(input string tag);
    exp_t e;
    int   n;
    n = 0;
    while (busy === 1'b1 && n < 4 * FRAME_CLKS) begin
      @(posedge clk); #2;
      n++;
    end
    chk({tag, "_busy_fall"}, 64'(busy), 64'd0);
    e = sb.pop_front();
    chk({tag, "_valid_at_fall"}, 64'(miim_rddata_valid), 64'(e.rd));
    chk({tag, "_rddata"}, 64'(miim_rddata), 64'(e.data));
    chk({tag, "_rderr"}, 64'(miim_rderr), 64'(e.err));
    chk({tag, "_mdc_idle"}, 64'(mdc), 64'd0);
    chk({tag, "_oe_idle"}, 64'(mdio_oe), 64'd0);
    chk({tag, "_mdo_idle"}, 64'(mdio_o), 64'd1);
    @(negedge clk); #1;
    chk({tag, "_busy_len"}, 64'(busy_len), 64'(FRAME_CLKS));
    chk({tag, "_frame"}, cap, e.frame);
    chk({tag, "_oe_bits"}, cap_oe, e.oe);
    repeat (3) @(negedge clk);
    #1;
    chk({tag, "_valid_cnt"}, 64'(vld_cnt), 64'(e.rd));
    chk({tag, "_valid_low"}, 64'(miim_rddata_valid), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    int n;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rddata", 64'(miim_rddata), 64'd0);
    chk("rst_valid", 64'(miim_rddata_valid), 64'd0);
    chk("rst_rderr", 64'(miim_rderr), 64'd0);
    chk("rst_mdc", 64'(mdc), 64'd0);
    chk("rst_mdo", 64'(mdio_o), 64'd1);
    chk("rst_oe", 64'(mdio_oe), 64'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    phy_on = 1'b0;
    request(1'b1, 1'b0, 5'd0, 5'd0, 16'h0100);
    finish_frame("wr0");

    phy_on = 1'b1;
    phy_data = 16'h0283;
    request(1'b0, 1'b1, 5'd0, 5'd2, 16'h0000);
    finish_frame("rd_phy");

    phy_on = 1'b0;
    request(1'b0, 1'b1, 5'h01, 5'h03, 16'h0000);
    finish_frame("rd_nophy");

    phy_on = 1'b1;
    phy_data = 16'hC35A;
    f0 = frame_cnt;
    request(1'b0, 1'b1, 5'h1F, 5'h11, 16'h0000);
    repeat (100) @(posedge clk);
    #1;
    miim_wrdata = 16'hAAAA;
    miim_wren = 1'b1;
    @(posedge clk); #1;
    miim_wren = 1'b0;
    finish_frame("rd_ignore");
    repeat (20) @(posedge clk);
    #1;
    chk("ignore_frames", 64'(frame_cnt - f0), 64'd1);
    chk("ignore_idle", 64'(busy), 64'd0);

    request(1'b1, 1'b1, 5'h15, 5'h0A, 16'h5AC3);
    finish_frame("wr_rd_same");

    // Abandon a read part-way through with reset
    phy_on = 1'b1;
    phy_data = 16'h1111;
    @(posedge clk); #1;
    miim_phyad = 5'h02;
    miim_regad = 5'h04;
    miim_rden = 1'b1;
    @(posedge clk); #1;
    miim_rden = 1'b0;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (bit_idx != 40 && n < 2 * FRAME_CLKS);
    chk("rst_mid_reach_bit40", 64'(bit_idx), 64'd40);
    rst = 1'b1;
    #1;
    chk("rst_mid_mdc", 64'(mdc), 64'd0);
    chk("rst_mid_oe", 64'(mdio_oe), 64'd0);
    chk("rst_mid_mdo", 64'(mdio_o), 64'd1);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_rddata", 64'(miim_rddata), 64'd0);
    chk("rst_mid_rderr", 64'(miim_rderr), 64'd0);
    chk("rst_mid_valid", 64'(miim_rddata_valid), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_rddata = '0;
    exp_rderr  = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("rst_mid_valid_cnt", 64'(vld_cnt), 64'd0);

    phy_data = 16'h7E81;
    request(1'b0, 1'b1, 5'h0C, 5'h1D, 16'h0000);
    finish_frame("rd_after_rst");

    request(1'b1, 1'b0, 5'h03, 5'h1B, 16'hF00D);
    finish_frame("wr_after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
